// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the four-lane select/arbiter block.
//   LANES     number of requesters
//   SEL_W     width of a lane select code
//   MAX_W     widest lane word lane_slice() can extract
//   state_e   output register occupancy: IDLE (empty) / HOLD (full)
//   lane_slice(data_in, width, i) returns lane i of a packed word vector
package mux_arb_pkg;

   localparam int unsigned LANES = 4;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned MAX_W = 64;

   typedef enum logic {
      IDLE,
      HOLD
   } state_e;

   // Lane words are packed lane 0 at the LSBs. The caller keeps the low
   // 'width' bits of the result; anything above belongs to the next lane.
   function automatic logic [MAX_W-1:0] lane_slice(input logic [LANES*MAX_W-1:0] data_in,
                                                   input int unsigned            width,
                                                   input logic [SEL_W-1:0]       i);
      logic [LANES*MAX_W-1:0] shifted;
      shifted = data_in >> (32'(i) * width);
      return shifted[MAX_W-1:0];
   endfunction

endpackage

// File: rtl/arb_pick4.sv
// Combinational winner selection among four lane requests.
//   i_req      per-lane request bits
//   i_ptr      round-robin start lane (highest priority this cycle)
//   i_mode     0 = round-robin from i_ptr, 1 = fixed priority (lane 0 highest)
//   o_winner   index of the chosen lane (0 when nothing requests)
//   o_any_req  at least one lane is requesting
module arb_pick4
   import mux_arb_pkg::*;
(
   input  logic [LANES-1:0] i_req,
   input  logic [SEL_W-1:0] i_ptr,
   input  logic             i_mode,
   output logic [SEL_W-1:0] o_winner,
   output logic             o_any_req
);

   logic [SEL_W-1:0] w_idx;
   logic             w_found;

   always_comb begin
      o_winner  = '0;
      o_any_req = |i_req;
      w_idx     = '0;
      w_found   = 1'b0;
      if (i_mode) begin
         // Scan downward so the lowest requesting lane is the last write.
         for (int k = LANES - 1; k >= 0; k--) begin
            if (i_req[k]) o_winner = SEL_W'(k);
         end
      end else begin
         // Two-bit add wraps, giving ptr, ptr+1, ... mod 4.
         for (int k = 0; k < LANES; k++) begin
            w_idx = i_ptr + SEL_W'(k);
            if (!w_found && i_req[w_idx]) begin
               o_winner = w_idx;
               w_found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester arbiter sharing one 4:1 data-select path, with a one-entry
// output register presented over valid/ready.
//   WIDTH      lane word width (1..MAX_W)
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = round-robin, 1 = fixed priority (lane 0 highest)
//   req        per-lane valid
//   data_in    packed lane words, lane i at [i*WIDTH +: WIDTH]
//   gnt        one-hot (or zero) combinational accept
//   sel        lane index of the word in the output register
//   out_data   registered captured word
//   out_valid  output register holds an undelivered word
//   out_ready  downstream accept
//   busy       same as out_valid
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mode,
   input  logic [LANES-1:0]       req,
   input  logic [LANES*WIDTH-1:0] data_in,
   output logic [LANES-1:0]       gnt,
   output logic [SEL_W-1:0]       sel,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy
);

   state_e             r_state;
   state_e             w_state_next;
   logic [SEL_W-1:0]   r_ptr;
   logic [SEL_W-1:0]   r_sel;
   logic [WIDTH-1:0]   r_data;

   logic [SEL_W-1:0]       w_winner;
   logic                   w_any_req;
   logic                   w_slot_free;
   logic                   w_grant;
   logic [LANES*MAX_W-1:0] w_data_ext;
   logic [MAX_W-1:0]       w_word_ext;
   logic [WIDTH-1:0]       w_word;

   arb_pick4 u_pick (
      .i_req     (req),
      .i_ptr     (r_ptr),
      .i_mode    (mode),
      .o_winner  (w_winner),
      .o_any_req (w_any_req)
   );

   // Word mux: widen to the package's fixed vector, slice, keep WIDTH bits.
   assign w_data_ext = (LANES*MAX_W)'(data_in);
   assign w_word_ext = lane_slice(w_data_ext, WIDTH, w_winner);
   assign w_word     = w_word_ext[WIDTH-1:0];

   // The register can accept a word if empty or if it drains on this edge.
   assign w_slot_free = (r_state == IDLE) || out_ready;
   // rst_n gates the grant so nothing is accepted while reset is held.
   assign w_grant     = rst_n && w_slot_free && w_any_req;

   always_comb begin
      gnt = '0;
      if (w_grant) gnt[w_winner] = 1'b1;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: if (w_grant) w_state_next = HOLD;
         HOLD: begin
            if (w_grant)        w_state_next = HOLD;
            else if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Data, select and pointer only move on a grant; a plain drain keeps them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_sel  <= '0;
         r_ptr  <= '0;
      end else if (w_grant) begin
         r_data <= w_word;
         r_sel  <= w_winner;
         r_ptr  <= w_winner + SEL_W'(1);
      end
   end

   assign out_data  = r_data;
   assign sel       = r_sel;
   assign out_valid = (r_state == HOLD);
   assign busy      = (r_state == HOLD);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus a random
// run compared against a lane-level behavioural model.
module tb_mux4_rr_arbiter;

   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic           mode;
   logic [3:0]     req;
   logic [4*W-1:0] data_in;
   logic [3:0]     gnt;
   logic [1:0]     sel;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic           busy;

   int checks;
   int errors;

   // Behavioural model: occupancy, held word/lane, next round-robin lane.
   bit         m_valid;
   logic [7:0] m_data;
   int         m_sel;
   int         m_ptr;

   mux4_rr_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .req       (req),
      .data_in   (data_in),
      .gnt       (gnt),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4*W-1:0] pack(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
      return {d, c, b, a};
   endfunction

   function automatic void model_reset();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_sel   = 0;
      m_ptr   = 0;
   endfunction

   // Expected grant from the arbitration rules applied to the current inputs.
   function automatic int exp_winner();
      if (!rst_n) return -1;
      if (m_valid && !out_ready) return -1;
      if (mode) begin
         for (int i = 0; i < 4; i++) if (req[i]) return i;
      end else begin
         for (int k = 0; k < 4; k++) if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_gnt();
      int w;
      w = exp_winner();
      if (w < 0) return 4'b0000;
      return 4'(1 << w);
   endfunction

   // Advance one clock and update the model with what the edge should do.
   task automatic tick();
      int w;
      w = exp_winner();
      @(posedge clk);
      if (w >= 0) begin
         m_valid = 1'b1;
         m_data  = data_in[w*W +: W];
         m_sel   = w;
         m_ptr   = (w + 1) % 4;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      mode      = 1'b0;
      req       = 4'b1111;
      out_ready = 1'b1;
      data_in   = pack(8'h11, 8'h22, 8'h33, 8'h44);
      model_reset();
      #12;
      checks++;
      if (gnt !== 4'b0000) begin
         errors++;
         $display("FAIL reset_gnt: got %b want 0000", gnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req   = 4'b0000;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL idle_gnt cycle %0d: got %b want 0000", c, gnt);
         end
         tick();
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0 || sel !== 2'd0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL idle_outputs cycle %0d: got v=%b b=%b sel=%0d d=%h want 0 0 0 00",
                     c, out_valid, busy, sel, out_data);
         end
      end
   endtask

   task automatic test_rr_sequence();
      logic [3:0] exp_g [5];
      logic [7:0] exp_d [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_d = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
      mode      = 1'b0;
      req       = 4'b1111;
      out_ready = 1'b1;
      data_in   = pack(8'hA0, 8'hB1, 8'hC2, 8'hD3);
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (gnt !== exp_g[c]) begin
            errors++;
            $display("FAIL rr_gnt step %0d: got %b want %b", c, gnt, exp_g[c]);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d[c]) begin
            errors++;
            $display("FAIL rr_data step %0d: got v=%b d=%h want v=1 d=%h",
                     c, out_valid, out_data, exp_d[c]);
         end
      end
   endtask

   task automatic test_fixed_priority();
      mode      = 1'b1;
      req       = 4'b1010;
      out_ready = 1'b1;
      data_in   = pack(8'h01, 8'h5B, 8'h03, 8'h7D);
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL fixed_gnt step %0d: got %b want 0010", c, gnt);
         end
         tick();
         checks++;
         if (out_data !== 8'h5B || sel !== 2'd1) begin
            errors++;
            $display("FAIL fixed_data step %0d: got d=%h sel=%0d want 5b 1", c, out_data, sel);
         end
      end
      // ptr is now 2; round-robin scan 2,3,... finds lane 3 first.
      mode = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b1000) begin
         errors++;
         $display("FAIL mode_switch_gnt: got %b want 1000", gnt);
      end
      tick();
      checks++;
      if (out_data !== 8'h7D || sel !== 2'd3) begin
         errors++;
         $display("FAIL mode_switch_data: got d=%h sel=%0d want 7d 3", out_data, sel);
      end
   endtask

   task automatic test_hold_stall();
      req       = 4'b0000;
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL pre_stall_drain: got out_valid=%b want 0", out_valid);
      end
      req       = 4'b0100;
      out_ready = 1'b0;
      data_in   = pack(8'h00, 8'h00, 8'h5A, 8'h00);
      #1;
      checks++;
      if (gnt !== 4'b0100) begin
         errors++;
         $display("FAIL stall_first_gnt: got %b want 0100", gnt);
      end
      tick();
      data_in = pack(8'h00, 8'h00, 8'hE7, 8'h00);
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL stall_gnt cycle %0d: got %b want 0000", c, gnt);
         end
         checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 8'h5A || sel !== 2'd2) begin
            errors++;
            $display("FAIL stall_hold cycle %0d: got v=%b b=%b d=%h sel=%0d want 1 1 5a 2",
                     c, out_valid, busy, out_data, sel);
         end
         tick();
      end
      req       = 4'b0000;
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h5A || sel !== 2'd2) begin
         errors++;
         $display("FAIL stall_drain: got v=%b b=%b d=%h sel=%0d want 0 0 5a 2",
                  out_valid, busy, out_data, sel);
      end
   endtask

   task automatic test_back_to_back();
      req       = 4'b0010;
      out_ready = 1'b0;
      data_in   = pack(8'h3C, 8'h99, 8'h00, 8'h00);
      tick();
      req       = 4'b0001;
      out_ready = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL b2b_gnt: got %b want 0001", gnt);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || sel !== 2'd0) begin
         errors++;
         $display("FAIL b2b_data: got v=%b d=%h sel=%0d want 1 3c 0", out_valid, out_data, sel);
      end
   endtask

   task automatic test_reset_mid_hold();
      // Still holding lane 0's word; stall it then pull reset.
      req       = 4'b1111;
      out_ready = 1'b0;
      data_in   = pack(8'h10, 8'h20, 8'h30, 8'h40);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
         errors++;
         $display("FAIL rst_mid_hold: got v=%b b=%b g=%b want 0 0 0000", out_valid, busy, gnt);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || gnt !== 4'b0000) begin
         errors++;
         $display("FAIL rst_held: got v=%b d=%h g=%b want 0 00 0000", out_valid, out_data, gnt);
      end
      rst_n = 1'b1;
      mode  = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL post_rst_gnt: got %b want 0001", gnt);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 || sel !== 2'd0) begin
         errors++;
         $display("FAIL post_rst_data: got v=%b d=%h sel=%0d want 1 10 0", out_valid, out_data, sel);
      end
   endtask

   task automatic test_random();
      logic [3:0] eg;
      for (int c = 0; c < 400; c++) begin
         req       = 4'($urandom_range(0, 15));
         mode      = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         data_in   = 32'($urandom);
         #1;
         eg = exp_gnt();
         checks++;
         if (gnt !== eg) begin
            errors++;
            $display("FAIL rand_gnt cycle %0d: got %b want %b (req=%b mode=%b rdy=%b)",
                     c, gnt, eg, req, mode, out_ready);
         end
         tick();
         checks++;
         if (out_valid !== m_valid || busy !== m_valid) begin
            errors++;
            $display("FAIL rand_valid cycle %0d: got v=%b b=%b want %b", c, out_valid, busy, m_valid);
         end
         checks++;
         if (out_data !== m_data || sel !== 2'(m_sel)) begin
            errors++;
            $display("FAIL rand_data cycle %0d: got d=%h sel=%0d want d=%h sel=%0d",
                     c, out_data, sel, m_data, m_sel);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_rr_sequence();
      test_fixed_priority();
      test_hold_stall();
      test_back_to_back();
      test_reset_mid_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
